// File: rtl/seg2hex_scan.sv
// Snoops a scanned, multiplexed 7-segment display bus and reassembles the hex
// digits being shown into a full frame, flagging illegal patterns per digit.
module seg2hex_scan #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        seg_d,
    input  logic [NDIG-1:0]   seg_com,
    output logic [4*NDIG-1:0] hex_out,
    output logic [NDIG-1:0]   dp_out,
    output logic [NDIG-1:0]   err_out,
    output logic              frame_valid,
    output logic              com_err
);
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE - 1);

    // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
    function automatic logic [4:0] decodeSeg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3f:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5b:   r = 5'h02;
            7'h4f:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6d:   r = 5'h05;
            7'h7d:   r = 5'h06;
            7'h27:   r = 5'h07;
            7'h7f:   r = 5'h08;
            7'h6f:   r = 5'h09;
            7'h5f:   r = 5'h0a;
            7'h7c:   r = 5'h0b;
            7'h58:   r = 5'h0c;
            7'h5e:   r = 5'h0d;
            7'h7b:   r = 5'h0e;
            7'h71:   r = 5'h0f;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [7:0]        rSeg_q, rSeg_d;
    logic [NDIG-1:0]   rCom_q, rCom_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NDIG-1:0]   mask_q, mask_d;
    logic [4*NDIG-1:0] slotHex_q, slotHex_d;
    logic [NDIG-1:0]   slotDp_q, slotDp_d;
    logic [NDIG-1:0]   slotErr_q, slotErr_d;
    logic [4*NDIG-1:0] hex_q, hex_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic              frameValid_q, frameValid_d;
    logic              comErr_q, comErr_d;

    logic       sameIn;
    logic       stableEdge;
    logic       oneHot;
    logic [4:0] dec;

    assign sameIn     = (seg_d == rSeg_q) && (seg_com == rCom_q);
    assign stableEdge = sameIn && (cnt_q == CNT_CAP);
    assign oneHot     = (rCom_q != '0) && ((rCom_q & (rCom_q - NDIG'(1))) == '0);
    assign dec        = decodeSeg(rSeg_q[6:0]);

    // Capture fires once per dwell: the counter passes STABLE-1 only once
    // before saturating, so a long dwell cannot write its slot again.
    always_comb begin
        rSeg_d       = rSeg_q;
        rCom_d       = rCom_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        slotHex_d    = slotHex_q;
        slotDp_d     = slotDp_q;
        slotErr_d    = slotErr_q;
        hex_d        = hex_q;
        dp_d         = dp_q;
        err_d        = err_q;
        frameValid_d = 1'b0;
        comErr_d     = 1'b0;

        if (!sameIn) begin
            rSeg_d = seg_d;
            rCom_d = seg_com;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (stableEdge) begin
            if (oneHot) begin
                for (int k = 0; k < NDIG; k++) begin
                    if (rCom_q[k]) begin
                        slotHex_d[4*k +: 4] = dec[3:0];
                        slotDp_d[k]         = rSeg_q[7];
                        slotErr_d[k]        = dec[4];
                    end
                end
                mask_d = mask_q | rCom_q;
                if (&mask_d) begin
                    hex_d        = slotHex_d;
                    dp_d         = slotDp_d;
                    err_d        = slotErr_d;
                    frameValid_d = 1'b1;
                    mask_d       = '0;
                end
            end else if (rCom_q != '0) begin
                comErr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rSeg_q       <= '0;
            rCom_q       <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            slotHex_q    <= '0;
            slotDp_q     <= '0;
            slotErr_q    <= '0;
            hex_q        <= '0;
            dp_q         <= '0;
            err_q        <= '0;
            frameValid_q <= 1'b0;
            comErr_q     <= 1'b0;
        end else begin
            rSeg_q       <= rSeg_d;
            rCom_q       <= rCom_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            slotHex_q    <= slotHex_d;
            slotDp_q     <= slotDp_d;
            slotErr_q    <= slotErr_d;
            hex_q        <= hex_d;
            dp_q         <= dp_d;
            err_q        <= err_d;
            frameValid_q <= frameValid_d;
            comErr_q     <= comErr_d;
        end
    end

    assign hex_out     = hex_q;
    assign dp_out      = dp_q;
    assign err_out     = err_q;
    assign frame_valid = frameValid_q;
    assign com_err     = comErr_q;

endmodule

// File: tb/tb_seg2hex_scan.sv
// Self-checking bench for seg2hex_scan: hand-built scan tables, corner-case
// sequences and random scans compared against a run-length reference model.
module tb_seg2hex_scan;
    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_d;
    logic [3:0]  seg_com;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  err_out;
    logic        frame_valid;
    logic        com_err;

    always #5 clk = ~clk;

    seg2hex_scan #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_d       (seg_d),
        .seg_com     (seg_com),
        .hex_out     (hex_out),
        .dp_out      (dp_out),
        .err_out     (err_out),
        .frame_valid (frame_valid),
        .com_err     (com_err)
    );

    int compareCount = 0;
    int failCount    = 0;
    int fvCount      = 0;
    int comErrCount  = 0;

    logic [6:0] codes [16];

    // Reference model: counts how many consecutive edges the current pair has
    // been seen, and captures on the edge where that count reaches STABLE+1.
    logic [7:0]  prevSeg;
    logic [3:0]  prevCom;
    int          runLen;
    logic [3:0]  wHex [4];
    logic [3:0]  wDp, wErr, mask;
    logic [15:0] mHex;
    logic [3:0]  mDp, mErr;
    logic        mFv, mComErr;

    function automatic logic [4:0] modelDecode(input logic [6:0] s);
        for (int v = 0; v < 16; v++) begin
            if (codes[v] == s) return {1'b0, 4'(v)};
        end
        return 5'h10;
    endfunction

    task automatic modelReset();
        prevSeg = '0; prevCom = '0; runLen = 1;
        for (int i = 0; i < NDIG; i++) wHex[i] = '0;
        wDp = '0; wErr = '0; mask = '0;
        mHex = '0; mDp = '0; mErr = '0; mFv = 1'b0; mComErr = 1'b0;
    endtask

    task automatic modelStep();
        int k;
        int ones;
        logic [4:0] d;
        k = 0;
        if (seg_d == prevSeg && seg_com == prevCom) begin
            if (runLen < 1000) runLen++;
        end else begin
            prevSeg = seg_d; prevCom = seg_com; runLen = 1;
        end
        mFv = 1'b0; mComErr = 1'b0;
        if (runLen == STABLE + 1) begin
            ones = $countones(seg_com);
            if (ones == 1) begin
                for (int i = 0; i < NDIG; i++) if (seg_com[i]) k = i;
                d = modelDecode(seg_d[6:0]);
                wHex[k] = d[3:0]; wErr[k] = d[4]; wDp[k] = seg_d[7]; mask[k] = 1'b1;
                if (mask == 4'hf) begin
                    for (int i = 0; i < NDIG; i++) mHex[4*i +: 4] = wHex[i];
                    mDp = wDp; mErr = wErr; mFv = 1'b1; mask = '0;
                end
            end else if (ones > 1) begin
                mComErr = 1'b1;
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("hex_out", 32'(hex_out), 32'(mHex));
        checkVal("dp_out", 32'(dp_out), 32'(mDp));
        checkVal("err_out", 32'(err_out), 32'(mErr));
        checkVal("frame_valid", 32'(frame_valid), 32'(mFv));
        checkVal("com_err", 32'(com_err), 32'(mComErr));
        if (frame_valid === 1'b1) fvCount++;
        if (com_err === 1'b1) comErrCount++;
    endtask

    task automatic applyStimulus(input logic [7:0] seg, input logic [3:0] com);
        @(negedge clk);
        seg_d = seg; seg_com = com;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic dwell(input logic [7:0] seg, input logic [3:0] com, input int n);
        repeat (n) applyStimulus(seg, com);
    endtask

    task automatic scanDigit(input int d, input logic [7:0] seg, input int n);
        dwell(seg, 4'(1 << d), n);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; seg_d = '0; seg_com = '0;
        #1;
        modelReset();
        checkOutput();
        checkVal("reset hex_out", 32'(hex_out), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  seg;
        logic [3:0]  com;
        int          cycles;
        int          expFrames;
        logic [15:0] expHex;
        logic [3:0]  expDp;
        logic [3:0]  expErr;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] expH;
        logic [7:0]  s;
        logic [3:0]  c;
        int          r;

        codes = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h27,
                  7'h7f, 7'h6f, 7'h5f, 7'h7c, 7'h58, 7'h5e, 7'h7b, 7'h71};
        rst_n = 1'b0; seg_d = '0; seg_com = '0;
        modelReset();

        vecs.push_back(vec_t'{8'h06, 4'b0001, 7, 0, 16'h0000, 4'h0, 4'h0});
        vecs.push_back(vec_t'{8'h5b, 4'b0010, 7, 0, 16'h0000, 4'h0, 4'h0});
        vecs.push_back(vec_t'{8'h4f, 4'b0100, 7, 0, 16'h0000, 4'h0, 4'h0});
        vecs.push_back(vec_t'{8'h66, 4'b1000, 7, 1, 16'h4321, 4'h0, 4'h0});
        vecs.push_back(vec_t'{8'h3f, 4'b0001, 7, 0, 16'h4321, 4'h0, 4'h0});
        vecs.push_back(vec_t'{8'hdb, 4'b0010, 7, 0, 16'h4321, 4'h0, 4'h0});
        vecs.push_back(vec_t'{8'h00, 4'b0100, 7, 0, 16'h4321, 4'h0, 4'h0});
        vecs.push_back(vec_t'{8'hef, 4'b1000, 7, 1, 16'h9020, 4'b1010, 4'b0100});
        vecs.push_back(vec_t'{8'h7f, 4'b0001, 7, 0, 16'h9020, 4'b1010, 4'b0100});
        vecs.push_back(vec_t'{8'h00, 4'b0000, 3, 0, 16'h9020, 4'b1010, 4'b0100});
        vecs.push_back(vec_t'{8'h06, 4'b0010, 7, 0, 16'h9020, 4'b1010, 4'b0100});
        vecs.push_back(vec_t'{8'h00, 4'b0000, 3, 0, 16'h9020, 4'b1010, 4'b0100});
        vecs.push_back(vec_t'{8'h7e, 4'b0100, 7, 0, 16'h9020, 4'b1010, 4'b0100});
        vecs.push_back(vec_t'{8'h71, 4'b1000, 7, 1, 16'hf018, 4'h0, 4'b0100});

        doReset();
        foreach (vecs[i]) begin
            fvCount = 0;
            dwell(vecs[i].seg, vecs[i].com, vecs[i].cycles);
            checkVal($sformatf("vec%0d frames", i), 32'(fvCount), 32'(vecs[i].expFrames));
            checkVal($sformatf("vec%0d hex", i), 32'(hex_out), 32'(vecs[i].expHex));
            checkVal($sformatf("vec%0d dp", i), 32'(dp_out), 32'(vecs[i].expDp));
            checkVal($sformatf("vec%0d err", i), 32'(err_out), 32'(vecs[i].expErr));
        end

        // Sweep all 16 legal codes, decimal point on odd frames.
        for (int f = 0; f < 4; f++) begin
            fvCount = 0;
            expH = '0;
            for (int d = 0; d < 4; d++) begin
                scanDigit(d, {f[0], codes[4*f + d]}, STABLE + 2);
                expH[4*d +: 4] = 4'(4*f + d);
            end
            checkVal($sformatf("sweep%0d frames", f), 32'(fvCount), 32'd1);
            checkVal($sformatf("sweep%0d hex", f), 32'(hex_out), 32'(expH));
            checkVal($sformatf("sweep%0d dp", f), 32'(dp_out), f[0] ? 32'hf : 32'h0);
            checkVal($sformatf("sweep%0d err", f), 32'(err_out), 32'h0);
        end

        // Dwell of exactly STABLE edges must not capture; STABLE+1 must.
        doReset();
        for (int d = 1; d < 4; d++) scanDigit(d, 8'h6d, 7);
        fvCount = 0;
        scanDigit(0, 8'h27, STABLE);
        dwell(8'h00, 4'b0000, 3);
        checkVal("hold4 frames", 32'(fvCount), 32'd0);
        scanDigit(0, 8'h27, STABLE + 1);
        dwell(8'h00, 4'b0000, 2);
        checkVal("hold5 frames", 32'(fvCount), 32'd1);
        checkVal("hold5 hex", 32'(hex_out), 32'h5557);

        // One-cycle glitch restarts the full dwell.
        doReset();
        for (int d = 1; d < 4; d++) scanDigit(d, 8'h06, 7);
        fvCount = 0;
        scanDigit(0, 8'h4f, 3);
        scanDigit(0, 8'h00, 1);
        scanDigit(0, 8'h4f, STABLE);
        checkVal("glitch early frames", 32'(fvCount), 32'd0);
        scanDigit(0, 8'h4f, 1);
        checkVal("glitch frames", 32'(fvCount), 32'd1);
        checkVal("glitch hex", 32'(hex_out), 32'h1113);

        // Multi-hot select: one pulse, no digits marked.
        doReset();
        comErrCount = 0;
        dwell(8'h66, 4'b0110, 10);
        checkVal("com_err pulses", 32'(comErrCount), 32'd1);
        fvCount = 0;
        scanDigit(0, 8'h06, 7);
        scanDigit(3, 8'h06, 7);
        checkVal("com_err mask frames", 32'(fvCount), 32'd0);
        scanDigit(1, 8'h06, 7);
        scanDigit(2, 8'h06, 7);
        checkVal("com_err later frames", 32'(fvCount), 32'd1);
        checkVal("com_err hex", 32'(hex_out), 32'h1111);

        // Rescan of digit 1 before the frame completes: later value wins.
        doReset();
        fvCount = 0;
        scanDigit(1, 8'h5b, 7);
        scanDigit(0, 8'h3f, 7);
        scanDigit(1, 8'h6f, 7);
        scanDigit(2, 8'h06, 7);
        checkVal("rescan early frames", 32'(fvCount), 32'd0);
        scanDigit(3, 8'h66, 7);
        checkVal("rescan frames", 32'(fvCount), 32'd1);
        checkVal("rescan hex", 32'(hex_out), 32'h4190);

        // Reset mid-frame discards the partial frame.
        for (int d = 0; d < 3; d++) scanDigit(d, 8'h7f, 7);
        doReset();
        checkVal("midreset dp", 32'(dp_out), 32'h0);
        checkVal("midreset fv", 32'(frame_valid), 32'h0);
        fvCount = 0;
        for (int d = 0; d < 3; d++) scanDigit(d, 8'h7f, 7);
        checkVal("midreset partial frames", 32'(fvCount), 32'd0);
        scanDigit(3, 8'h7f, 7);
        checkVal("midreset frames", 32'(fvCount), 32'd1);
        checkVal("midreset hex", 32'(hex_out), 32'h8888);

        // Random scans checked cycle by cycle against the model.
        doReset();
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      c = 4'(1 << $urandom_range(0, 3));
            else if (r < 8) c = 4'b0000;
            else            c = 4'($urandom);
            if ($urandom_range(0, 9) < 7) s = {1'($urandom), codes[$urandom_range(0, 15)]};
            else                          s = 8'($urandom);
            dwell(s, c, int'($urandom_range(1, 8)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
